// File: rtl/gray_decoder.sv
// gray_decoder: receive-side Gray-code checker.
// Decodes each accepted Gray sample to binary and registers it with a one-cycle
// valid pulse. It also checks that each sample is a hold or a +1 step from the
// previous one, and counts forward wraps (max -> 0) in a saturating counter.
// Optional feature macro: GRAY_DEC_RESYNC_EN. When it is defined, the first
// sample after an error becomes the new reference and Step_Err clears.
module gray_decoder #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [WIDTH-1:0] Gray_In,
  output logic [WIDTH-1:0] Bin_Out,
  output logic             Bin_Valid,
  output logic             Step_Err,
  output logic             Overflow,
  output logic [CNT_W-1:0] Wrap_Cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,  // no reference sample yet
    TRACK = 2'b01,  // checking each sample against the previous one
    ERR   = 2'b10   // illegal step seen; decode only
  } state_e;

  localparam logic [WIDTH-1:0] BIN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Binary bit i is the XOR of Gray bits WIDTH-1 down to i.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < WIDTH; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;

  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] next_exp;

  // The previous accepted sample is always the value held in Bin_Out, so it
  // serves as the reference for the step check.
  assign dec      = gray2bin(Gray_In);
  assign next_exp = bin_q + 1'b1;

  // Next-state and datapath logic: decode, step check and wrap counting.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d = state_q;
    bin_d   = bin_q;
    valid_d = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    wrap_d  = wrap_q;

    if (En) begin
      bin_d   = dec;
      valid_d = 1'b1;
      unique case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK: begin
          if (dec == bin_q) begin
            state_d = TRACK;
          end else if (dec == next_exp) begin
            if (bin_q == BIN_MAX) begin
              ovf_d = 1'b1;
              if (wrap_q != CNT_MAX) begin
                wrap_d = wrap_q + 1'b1;
              end
            end
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
        ERR: begin
`ifdef GRAY_DEC_RESYNC_EN
          // This sample becomes the new reference, and checking resumes.
          err_d   = 1'b0;
          state_d = TRACK;
`else
          // The error is absorbing: only a reset leaves this state.
          state_d = ERR;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    if (!Reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Bin_Out   = bin_q;
  assign Bin_Valid = valid_q;
  assign Step_Err  = err_q;
  assign Overflow  = ovf_q;
  assign Wrap_Cnt  = wrap_q;

endmodule
